wb_regfile: RTL

//  Write-back stage plus register file of the 8-bit core. Sits directly

---
 rtl/wb_regfile.sv | 74 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and register file of the 8-bit core.
// One-entry write-back register commits to the array a cycle later.
module wb_regfile #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic          wb_pending
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs [NREG];
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  logic advance;
  logic commit;

  assign advance = !flush && !stall;
  assign commit  = advance && wb_valid;

  // Stage capture; address/data only load on a real write so
  // don't-care inputs never reach the stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (!stall) begin
      wb_valid <= wr_en;
      if (wr_en) begin
        wb_addr <= wr_addr;
        wb_data <= wr_data;
      end
    end
  end

  // Commit the pending entry into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports with bypass from the pending entry.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (wb_valid && wb_addr == rd_addr_a)
      rd_data_a = wb_data;
    if (wb_valid && wb_addr == rd_addr_b)
      rd_data_b = wb_data;
  end

  assign wb_pending = wb_valid;

endmodule
